seq_restoring_divider: RTL

- Iterative restoring divider, one quotient bit per clock, built around a single DVW+1-bit subtract stage.
- It is the inverse datapath to the ETM multiplier and ripple adders: it divides an 11-bit unsigned value, such as a shifted product or accumulated sum, by a 10-bit unsigned value.
- Used for post-layer normalisation and average-pooling scaling in the CNN datapath.
- Uses a valid/ready handshake on both ends so it can be placed between pipeline stages.

---
 rtl/seq_restoring_divider.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock.
// Valid/ready on both ends; divide-by-zero flagged in one cycle.
module seq_restoring_divider #(
  parameter int DW  = 11,
  parameter int DVW = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  dividend,
  input  logic [DVW-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  quotient,
  output logic [DVW-1:0] remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // dividend bits leave at the MSB while quotient bits enter at the LSB
  logic [DW-1:0]  dvd_q, dvd_d;
  logic [DVW-1:0] dvs_q, dvs_d;
  logic [DVW-1:0] part_q, part_d;
  logic [DW-1:0]  quo_q, quo_d;
  logic [DVW-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [DVW:0]   shifted;
  logic [DVW+1:0] diff;
  logic           borrow;
  logic [DVW-1:0] part_nxt;
  logic [DW-1:0]  dvd_nxt;

  // single subtract stage; borrow taken from an extra guard bit
  always_comb begin
    shifted  = {part_q, dvd_q[DW-1]};
    diff     = {1'b0, shifted} - {2'b00, dvs_q};
    borrow   = diff[DVW+1];
    part_nxt = borrow ? shifted[DVW-1:0] : diff[DVW-1:0];
    dvd_nxt  = {dvd_q[DW-2:0], ~borrow};
  end

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          part_d = '0;
          cnt_d  = CW'(DW - 1);
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend[DVW-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        part_d = part_nxt;
        dvd_d  = dvd_nxt;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quo_d   = dvd_nxt;
          rem_d   = part_nxt;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
